// File: rtl/conv_ctrl_if.sv
// Bundle between the convolution controller and its host, memories and MAC datapath.
// The controller takes the slave side; the host/datapath environment takes the master side.
interface conv_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              start_i;
    logic [ADDR_W:0]   size_x_i;
    logic [ADDR_W:0]   size_y_i;
    logic [ADDR_W-1:0] addr_x_o;
    logic [ADDR_W-1:0] addr_y_o;
    logic              rd_en_o;
    logic              acc_clr_o;
    logic              acc_en_o;
    logic [ADDR_W:0]   addr_z_o;
    logic              wr_z_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, size_x_i, size_y_i,
        input  addr_x_o, addr_y_o, rd_en_o, acc_clr_o, acc_en_o,
        input  addr_z_o, wr_z_o, busy_o, done_o
    );

    modport slave (
        input  start_i, size_x_i, size_y_i,
        output addr_x_o, addr_y_o, rd_en_o, acc_clr_o, acc_en_o,
        output addr_z_o, wr_z_o, busy_o, done_o
    );
endinterface

// File: rtl/conv_ctrl.sv
// Sequencing FSM for the convolution datapath: Z[i] = sum_j X[i-j]*Y[j], i = 0..N+M-2.
// Drives X/Y read addresses, MAC clear/enable and Z write address/strobe.
module conv_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    conv_ctrl_if.slave  bus
);
    localparam int AW1 = ADDR_W + 1;
    localparam logic [AW1-1:0]    SIZE_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [AW1-1:0]    ONE_W1   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_W    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [AW1:0]      TWO_W2   = {{ADDR_W{1'b0}}, 2'b10};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [AW1-1:0]    n_q, m_q, i_q, addr_z_q;
    logic [ADDR_W-1:0] j_q, jmax_q, addr_x_q;
    logic              acc_en_q;

    logic [AW1-1:0] n_sat_s, m_sat_s, ip1_s, jmin_w_s, mm1_s, jmax_w_s, xstart_s;
    logic           sizes_zero_s, last_i_s, j_end_s;

    always_comb begin
        n_sat_s      = (bus.size_x_i > SIZE_MAX) ? SIZE_MAX : bus.size_x_i;
        m_sat_s      = (bus.size_y_i > SIZE_MAX) ? SIZE_MAX : bus.size_y_i;
        sizes_zero_s = (n_sat_s == {AW1{1'b0}}) || (m_sat_s == {AW1{1'b0}});
        // jmin = max(0, i-N+1) written as (i+1 > N) to stay unsigned
        ip1_s        = i_q + ONE_W1;
        jmin_w_s     = (ip1_s > n_q) ? (ip1_s - n_q) : {AW1{1'b0}};
        mm1_s        = m_q - ONE_W1;
        jmax_w_s     = (i_q < mm1_s) ? i_q : mm1_s;
        xstart_s     = i_q - jmin_w_s;
        last_i_s     = (({1'b0, i_q} + TWO_W2) == ({1'b0, n_q} + {1'b0, m_q}));
        j_end_s      = (j_q == jmax_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = sizes_zero_s ? S_DONE : S_CLR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR:   state_d = S_READ;
            S_READ:  state_d = j_end_s ? S_DRAIN : S_READ;
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: state_d = last_i_s ? S_DONE : S_CLR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters and address registers; addresses only move when entering/continuing READ or WRITE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q      <= {AW1{1'b0}};
            m_q      <= {AW1{1'b0}};
            i_q      <= {AW1{1'b0}};
            j_q      <= {ADDR_W{1'b0}};
            jmax_q   <= {ADDR_W{1'b0}};
            addr_x_q <= {ADDR_W{1'b0}};
            addr_z_q <= {AW1{1'b0}};
            acc_en_q <= 1'b0;
        end else begin
            acc_en_q <= (state_q == S_READ);
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        n_q <= n_sat_s;
                        m_q <= m_sat_s;
                        i_q <= {AW1{1'b0}};
                    end
                end
                S_CLR: begin
                    j_q      <= jmin_w_s[ADDR_W-1:0];
                    jmax_q   <= jmax_w_s[ADDR_W-1:0];
                    addr_x_q <= xstart_s[ADDR_W-1:0];
                end
                S_READ: begin
                    if (!j_end_s) begin
                        j_q      <= j_q + ONE_W;
                        addr_x_q <= addr_x_q - ONE_W;
                    end
                end
                S_DRAIN: addr_z_q <= i_q;
                S_WRITE: begin
                    if (!last_i_s) begin
                        i_q <= i_q + ONE_W1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rd_en_o   = (state_q == S_READ);
        bus.acc_clr_o = (state_q == S_CLR);
        bus.wr_z_o    = (state_q == S_WRITE);
        bus.done_o    = (state_q == S_DONE);
        bus.busy_o    = (state_q == S_CLR) || (state_q == S_READ) ||
                        (state_q == S_DRAIN) || (state_q == S_WRITE);
        bus.acc_en_o  = acc_en_q;
        bus.addr_x_o  = addr_x_q;
        bus.addr_y_o  = j_q;
        bus.addr_z_o  = addr_z_q;
    end
endmodule
